// File: rtl/arr_out_drain.sv
// arr_out_drain: realigns skewed systolic-array column results into rows,
// buffers them in a row FIFO and streams them out one word per transfer.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, exp_rows   job start pulse and expected row count
//   col_dat, col_vld  skewed per-column results from the array
//   out_dat, out_vld  serialized word stream toward the host
//   out_rdy, out_last consumer ready and end-of-row marker
//   done, ovf         job complete and sticky overflow flag
//   skew_err, fill    sticky deskew error and FIFO row occupancy
module arr_out_drain #(
   parameter int WORDLEN = 8,
   parameter int COLS    = 16,
   parameter int DEPTH   = 4,
   parameter int CNTW    = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [CNTW-1:0]            exp_rows,
   input  logic [COLS*WORDLEN-1:0]    col_dat,
   input  logic [COLS-1:0]            col_vld,
   output logic [WORDLEN-1:0]         out_dat,
   output logic                       out_vld,
   input  logic                       out_rdy,
   output logic                       out_last,
   output logic                       done,
   output logic                       ovf,
   output logic                       skew_err,
   output logic [$clog2(DEPTH):0]     fill
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;
   localparam int RW = COLS * WORDLEN;
   localparam int IW = $clog2(COLS);

   typedef enum logic {
      S_IDLE,
      S_SEND
   } st_t;

   logic clr;
   assign clr = rst | start;

   // Deskew: column c is delayed by COLS-1-c stages so every column
   // of a row lines up with the last column.
   logic [RW-1:0]   al_row;
   logic [COLS-1:0] al_vld;

   genvar c;
   for (c = 0; c < COLS; c++) begin : g_col
      localparam int N = COLS - 1 - c;
      if (N == 0) begin : g_pass
         assign al_row[c*WORDLEN +: WORDLEN] =
            col_dat[c*WORDLEN +: WORDLEN];
         assign al_vld[c] = col_vld[c];
      end else begin : g_dly
         logic [N*WORDLEN-1:0] sd_d, sd_q;
         logic [N-1:0]         sv_d, sv_q;

         always_comb begin
            sd_d = '0;
            sv_d = '0;
            if (!clr) begin
               sd_d[WORDLEN-1:0] = col_dat[c*WORDLEN +: WORDLEN];
               sv_d[0]           = col_vld[c];
               for (int s = 1; s < N; s++) begin
                  sd_d[s*WORDLEN +: WORDLEN] =
                     sd_q[(s-1)*WORDLEN +: WORDLEN];
                  sv_d[s] = sv_q[s-1];
               end
            end
         end

         always_ff @(posedge clk) begin
            sd_q <= sd_d;
            sv_q <= sv_d;
         end

         assign al_row[c*WORDLEN +: WORDLEN] =
            sd_q[(N-1)*WORDLEN +: WORDLEN];
         assign al_vld[c] = sv_q[N-1];
      end
   end

   logic row_ok, row_bad;
   assign row_ok  = &al_vld;
   assign row_bad = (|al_vld) & ~row_ok;

   // Row FIFO
   logic [RW-1:0] mem_q [DEPTH];
   logic [RW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [FW-1:0] fill_q, fill_d;
   logic          ovf_q, ovf_d, skew_q, skew_d;
   logic          push, pop;

   // A full FIFO still accepts a row when the head leaves this cycle.
   assign push = row_ok & ((fill_q < FW'(DEPTH)) | pop);

   always_comb begin
      mem_d  = mem_q;
      wp_d   = wp_q;
      rp_d   = rp_q;
      fill_d = fill_q;
      ovf_d  = ovf_q | (row_ok & ~push);
      skew_d = skew_q | row_bad;
      if (clr) begin
         wp_d   = '0;
         rp_d   = '0;
         fill_d = '0;
         ovf_d  = 1'b0;
         skew_d = 1'b0;
      end else begin
         if (push) begin
            mem_d[wp_q] = al_row;
            wp_d        = wp_q + 1'b1;
         end
         if (pop) begin
            rp_d = rp_q + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
         endcase
      end
   end

   // Serializer FSM
   st_t             state_q, state_d;
   logic [RW-1:0]   hold_q, hold_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [CNTW-1:0] sent_q, sent_d;
   logic [CNTW-1:0] exp_q, exp_d;
   logic            done_q, done_d;
   logic            last_w, xfer;

   always_ff @(posedge clk) begin
      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (fill_q != '0) state_d = S_SEND;
            end
            S_SEND: begin
               if (xfer && last_w && fill_q == '0)
                  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      out_vld  = (state_q == S_SEND);
      last_w   = (idx_q == IW'(COLS - 1));
      out_last = out_vld & last_w;
      out_dat  = out_vld ? hold_q[idx_q*WORDLEN +: WORDLEN]
                         : '0;
      xfer     = out_vld & out_rdy;
      pop      = !clr && (fill_q != '0) &&
                 ((state_q == S_IDLE) || (xfer && last_w));
   end

   // Holding register, column index and row accounting
   always_comb begin
      hold_d = hold_q;
      idx_d  = idx_q;
      sent_d = sent_q;
      exp_d  = exp_q;
      if (rst) begin
         exp_d = '0;
      end else if (start) begin
         exp_d = exp_rows;
      end
      if (clr) begin
         hold_d = '0;
         idx_d  = '0;
         sent_d = '0;
      end else begin
         if (xfer) begin
            if (last_w) begin
               if (sent_q != '1) sent_d = sent_q + 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         if (pop) begin
            hold_d = mem_q[rp_q];
            idx_d  = '0;
         end
      end
      // Compare against the next count so done rises right after
      // the final transfer.
      done_d = !clr && (exp_q != '0) && (sent_d == exp_q);
   end

   always_ff @(posedge clk) begin
      mem_q  <= mem_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      fill_q <= fill_d;
      ovf_q  <= ovf_d;
      skew_q <= skew_d;
      hold_q <= hold_d;
      idx_q  <= idx_d;
      sent_q <= sent_d;
      exp_q  <= exp_d;
      done_q <= done_d;
   end

   assign done     = done_q;
   assign ovf      = ovf_q;
   assign skew_err = skew_q;
   assign fill     = fill_q;

endmodule

// File: doc/arr_out_drain.md
# arr_out_drain

Output drain stage directly downstream of the systolic array controlled by `ARR_CTRL`. It captures the skewed per-column results leaving the bottom of the PE array and realigns them into complete rows. It buffers those rows in a small row FIFO and serializes them as a WORDLEN-wide stream with a valid/ready handshake toward the host-side interface. It also counts delivered rows against an expected total, signals completion, and flags overflow and skew errors.

## Interface
- `WORDLEN`, 8: bits per result word.
- `COLS`, 16: number of array columns, ≥2.
- `DEPTH`, 4: row FIFO depth in rows; power of two, ≥2.
- `CNTW`, 16: width of row counters.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `start` in 1: single-cycle pulse. Latches `exp_rows` and flushes all internal state.
- `exp_rows` in CNTW: number of rows expected in this job. Sampled only when `start`=1.
- `col_dat` in COLS*WORDLEN: column c result is at bits [c*WORDLEN +: WORDLEN].
- `col_vld` in COLS: per-column valid bit from the array.
- `out_dat` out WORDLEN: serialized result word.
- `out_vld` out 1: `out_dat` is valid.
- `out_rdy` in 1: consumer accepts the word. A transfer occurs when `out_vld` & `out_rdy`.
- `out_last` out 1: the current word is column COLS-1 of its row.
- `done` out 1: all expected rows have been transferred.
- `ovf` out 1: sticky. An aligned row was dropped because the FIFO was full.
- `skew_err` out 1: sticky. After deskew, `col_vld` bits disagreed.
- `fill` out $clog2(DEPTH)+1: number of rows currently held in the FIFO.

## Operation
- **Skew model.** The array emits output row k skewed across columns: column c is valid at cycle T_k + c.
- **Deskew.**
  - Column c passes through COLS-1-c register stages for both data and valid. Column COLS-1 has no stages.
  - The aligned row is the combinational output of the deskew stages. It is valid when all deskewed valid bits are 1.
  - If the deskewed valid bits are neither all-0 nor all-1, `skew_err` is set and that row is discarded.
- **FIFO push.**
  - An aligned valid row is pushed when `fill` < DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the row is dropped and `ovf` is set.
  - Read and write pointers wrap modulo DEPTH.
- **Serializer FSM, IDLE.**
  - `out_vld`=0.
  - If `fill` ≠ 0: pop the head row into the holding register, set column index = 0, go to SEND.
- **Serializer FSM, SEND.**
  - `out_vld`=1 and `out_dat` = holding[col_idx]. `out_last` = (col_idx == COLS-1).
  - On a transfer that is not the last word: col_idx increments.
  - On a transfer of the last word: `rows_sent` increments.
    - If `fill` ≠ 0, pop the next row in the same cycle, set col_idx = 0, and stay in SEND. There is no bubble between rows.
    - Otherwise go to IDLE.
  - `out_dat` and `out_last` hold stable while `out_vld`=1 and `out_rdy`=0.
- **Completion.**
  - `done` = (`exp_rows` ≠ 0) & (`rows_sent` == latched `exp_rows`), registered.
  - Rows that arrive after `done` is set are still drained; `rows_sent` saturates at all-ones.
- **`start` pulse.** Clears the FIFO, deskew stages, `rows_sent`, `ovf`, `skew_err` and `done`, and forces the FSM to IDLE. `start` has priority over a same-cycle push, pop or transfer.
- **Reset.** `rst` has the same effect as `start`, and also clears the latched `exp_rows` to 0.

## Timing
- **Reset values.** `out_dat`=0, `out_vld`=0, `out_last`=0, `done`=0, `ovf`=0, `skew_err`=0, `fill`=0.
- **Latency.**
  - Column 0 of a row valid at cycle t gives an aligned row at cycle t+COLS-1.
  - The FIFO is written at the end of that cycle, so `fill` increments at cycle t+COLS.
  - The pop into the holding register occurs at the end of cycle t+COLS.
  - First `out_vld`=1 is at cycle t+COLS+1.
- **Throughput.** With `out_rdy` held at 1, the block outputs one word per cycle. A row therefore takes COLS cycles to drain.
- **Sustained rate.** Sustained input must not exceed one row per COLS cycles, otherwise `ovf` is set.
- **`fill` update.** `fill` updates one cycle after a push or pop. A simultaneous push and pop leaves `fill` unchanged.
- **`done` timing.** `done` rises one cycle after the final transfer of the expected last row.

## Test plan
Parameters for all scenarios are COLS=4, WORDLEN=8, DEPTH=2.

- **Reset.** Hold `rst` for 2 cycles with `col_vld`=4'hF → all outputs are 0 and no row is pushed. Columns with deskew stages (c < COLS-1) see their register contents cleared; column COLS-1 has no stages, so its valid bit still reads 1 and the aligned row is not all-valid.
- **Single row.** Feed skewed row {col0=0x11, 0x22, 0x33, 0x44} with col0 at cycle 10 and `out_rdy`=1 → `out_vld` is high at cycles 15–18, words are 0x11, 0x22, 0x33, 0x44 in order, and `out_last` is high at cycle 18.
- **Back-pressure and completion.** Send 2 rows back-to-back 4 cycles apart with `exp_rows`=2, and hold `out_rdy`=0 for 3 cycles mid-row → data is held stable, there is no bubble between rows, `done`=1 one cycle after the 8th transfer, and `ovf`=0.
- **Overflow.** Send 4 rows 4 cycles apart with `out_rdy`=0 → `fill` reaches 2 and `ovf`=1. After raising `out_rdy`, exactly 3 rows are delivered (2 from the FIFO plus the holding register), in order.
- **Skew error.** Assert col0..col2 valid with the correct skew but omit col3 → `skew_err`=1, the row is dropped, and `fill` stays 0.
- **Restart mid-row.** Pulse `start` while in SEND mid-row with `exp_rows`=5 → the next cycle has `out_vld`=0, `fill`=0 and all flags 0; a following row drains normally from word 0.
